// File: rtl/alu_op_issuer_if.sv
// alu_op_issuer_if
//   Command and result handshake bundle between an initiator and the ALU
//   op issuer.
//   cmd_*  : command channel (valid/ready), operands, opcode, tag
//   res_*  : result channel (valid/ready), captured ALU outputs, dz flag, tag
//   master : the side that issues commands and consumes results
//   slave  : the issuer itself
interface alu_op_issuer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [1:0] cmd_op;
  logic [3:0] cmd_tag;

  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [3:0] res_rem;
  logic       res_carry;
  logic       res_ovf;
  logic       res_dz;
  logic [3:0] res_tag;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, res_ready,
    input  cmd_ready, res_valid, res_data, res_rem, res_carry, res_ovf,
           res_dz, res_tag
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, res_ready,
    output cmd_ready, res_valid, res_data, res_rem, res_carry, res_ovf,
           res_dz, res_tag
  );
endinterface

// File: rtl/alu_op_issuer.sv
// alu_op_issuer
//   Initiator-side driver for the combinational 4-bit ALU (add/sub/mul/div).
//   Takes one command at a time, drives the ALU inputs from registers, waits
//   SETTLE_CYCLES edges, captures the ALU outputs and returns them on the
//   result channel. Keeps saturating counts of completed ops and of
//   divide-by-zero ops.
//
//   Parameters
//     SETTLE_CYCLES : edges from driving ALU inputs to capture (>= 1)
//     CNT_W         : width of the op / divide-by-zero counters
//
//   Ports
//     i_clk, i_rst     : clock, synchronous active-high reset
//     bus (slave)      : command and result handshakes
//     o_alu_a/b        : ALU operands
//     o_alu_opcode     : ALU opcode (00 add, 01 sub, 10 mul, 11 div)
//     o_alu_sel        : ALU select, tied to 0
//     i_alu_result     : ALU result
//     i_alu_carry      : ALU carry flag
//     i_alu_overflow   : ALU overflow flag
//     i_alu_remainder  : ALU remainder
//     o_busy           : FSM not idle
//     o_op_count       : completed results, saturating
//     o_dz_count       : completed divide-by-zero results, saturating
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | cmd_ready high, ALU inputs hold the last issued command
//   WAIT   | ALU inputs driven, settle counter running toward capture
//   DONE   | result captured, res_valid high until the consumer takes it
module alu_op_issuer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  alu_op_issuer_if.slave    bus,
  output logic [3:0]        o_alu_a,
  output logic [3:0]        o_alu_b,
  output logic [1:0]        o_alu_opcode,
  output logic              o_alu_sel,
  input  logic [7:0]        i_alu_result,
  input  logic              i_alu_carry,
  input  logic              i_alu_overflow,
  input  logic [3:0]        i_alu_remainder,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_op_count,
  output logic [CNT_W-1:0]  o_dz_count
);

  // Settle counter only has to reach SETTLE_CYCLES-1.
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             w_accept;
  logic             w_capture;
  logic             w_release;
  logic             w_cmd_ready;
  logic             w_res_valid;
  logic             w_settled;

  logic [SW-1:0]    r_settle;
  logic [3:0]       r_alu_a;
  logic [3:0]       r_alu_b;
  logic [1:0]       r_alu_op;
  logic [3:0]       r_tag;
  logic             r_dz;

  logic [7:0]       r_res_data;
  logic [3:0]       r_res_rem;
  logic             r_res_carry;
  logic             r_res_ovf;
  logic             r_res_dz;
  logic [3:0]       r_res_tag;

  logic [CNT_W-1:0] r_op_count;
  logic [CNT_W-1:0] r_dz_count;

  assign w_settled = (r_settle == SW'(SETTLE_CYCLES - 1));

  // ---------------- FSM ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    w_cmd_ready = 1'b0;
    w_res_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_settled) begin
          w_capture   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_res_valid = 1'b1;
        if (bus.res_ready) begin
          w_release   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------- command latch / ALU drive ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_alu_a  <= 4'd0;
      r_alu_b  <= 4'd0;
      r_alu_op <= 2'd0;
      r_tag    <= 4'd0;
      r_dz     <= 1'b0;
    end else if (w_accept) begin
      r_alu_a  <= bus.cmd_a;
      r_alu_b  <= bus.cmd_b;
      r_alu_op <= bus.cmd_op;
      r_tag    <= bus.cmd_tag;
      // dz comes from the command itself, not from the ALU flags.
      r_dz     <= (bus.cmd_op == 2'b11) && (bus.cmd_b == 4'd0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_settle <= '0;
    end else if (w_accept) begin
      r_settle <= '0;
    end else if (r_state == S_WAIT) begin
      r_settle <= r_settle + SW'(1);
    end
  end

  // ---------------- result register ----------------
  // Fields stay put after the handshake; only res_valid (state) drops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_res_data  <= 8'd0;
      r_res_rem   <= 4'd0;
      r_res_carry <= 1'b0;
      r_res_ovf   <= 1'b0;
      r_res_dz    <= 1'b0;
      r_res_tag   <= 4'd0;
    end else if (w_capture) begin
      r_res_data  <= i_alu_result;
      r_res_rem   <= i_alu_remainder;
      r_res_carry <= i_alu_carry;
      r_res_ovf   <= i_alu_overflow;
      r_res_dz    <= r_dz;
      r_res_tag   <= r_tag;
    end
  end

  // ---------------- saturating status counters ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op_count <= '0;
      r_dz_count <= '0;
    end else if (w_release) begin
      if (r_op_count != '1) begin
        r_op_count <= r_op_count + CNT_W'(1);
      end
      if (r_res_dz && (r_dz_count != '1)) begin
        r_dz_count <= r_dz_count + CNT_W'(1);
      end
    end
  end

  // ---------------- outputs ----------------
  assign bus.cmd_ready = w_cmd_ready;
  assign bus.res_valid = w_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.res_rem   = r_res_rem;
  assign bus.res_carry = r_res_carry;
  assign bus.res_ovf   = r_res_ovf;
  assign bus.res_dz    = r_res_dz;
  assign bus.res_tag   = r_res_tag;

  assign o_alu_a      = r_alu_a;
  assign o_alu_b      = r_alu_b;
  assign o_alu_opcode = r_alu_op;
  assign o_alu_sel    = 1'b0;
  assign o_busy       = (r_state != S_IDLE);
  assign o_op_count   = r_op_count;
  assign o_dz_count   = r_dz_count;

endmodule

// File: tb/tb_alu_op_issuer.sv
// tb_alu_op_issuer
//   Directed bench for alu_op_issuer. Three instances:
//     u0 : SETTLE_CYCLES=1, CNT_W=8  (add, mul, div, div-by-zero, backpressure)
//     u1 : SETTLE_CYCLES=3, CNT_W=8  (settle latency, sub, reset mid-op)
//     u2 : SETTLE_CYCLES=1, CNT_W=2  (counter saturation)
//   Each instance sees a small combinational ALU model. Inputs are driven and
//   outputs sampled on the falling edge.
module tb_alu_op_issuer;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  alu_op_issuer_if if0 ();
  alu_op_issuer_if if1 ();
  alu_op_issuer_if if2 ();

  // {overflow, carry, remainder[3:0], result[7:0]}
  function automatic logic [13:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] op);
    logic [7:0] r;
    logic [3:0] rm;
    logic       c;
    logic       o;
    r  = 8'd0;
    rm = 4'd0;
    c  = 1'b0;
    o  = 1'b0;
    case (op)
      2'b00: begin
        r = {4'd0, a} + {4'd0, b};
        c = r[4];
        o = (a[3] == b[3]) && (r[3] != a[3]);
      end
      2'b01: begin
        r = {4'd0, a} - {4'd0, b};
        c = (a < b);
        o = (a[3] != b[3]) && (r[3] != a[3]);
      end
      2'b10: begin
        r = {4'd0, a} * {4'd0, b};
        c = |r[7:4];
        o = c;
      end
      default: begin
        if (b == 4'd0) begin
          r  = 8'hFF;
          rm = 4'hF;
          c  = 1'b1;
          o  = 1'b1;
        end else begin
          r  = {4'd0, a / b};
          rm = a % b;
        end
      end
    endcase
    return {o, c, rm, r};
  endfunction

  logic [3:0] a0, b0, rm0, a1, b1, rm1, a2, b2, rm2;
  logic [1:0] op0, op1, op2;
  logic [7:0] r0, r1, r2;
  logic       c0, o0, s0, bz0, c1, o1, s1, bz1, c2, o2, s2, bz2;
  logic [7:0] opc0, dzc0, opc1, dzc1;
  logic [1:0] opc2, dzc2;

  assign {o0, c0, rm0, r0} = alu_f(a0, b0, op0);
  assign {o1, c1, rm1, r1} = alu_f(a1, b1, op1);
  assign {o2, c2, rm2, r2} = alu_f(a2, b2, op2);

  alu_op_issuer #(.SETTLE_CYCLES(1), .CNT_W(8)) u0 (
    .i_clk(clk), .i_rst(rst), .bus(if0),
    .o_alu_a(a0), .o_alu_b(b0), .o_alu_opcode(op0), .o_alu_sel(s0),
    .i_alu_result(r0), .i_alu_carry(c0), .i_alu_overflow(o0), .i_alu_remainder(rm0),
    .o_busy(bz0), .o_op_count(opc0), .o_dz_count(dzc0)
  );

  alu_op_issuer #(.SETTLE_CYCLES(3), .CNT_W(8)) u1 (
    .i_clk(clk), .i_rst(rst), .bus(if1),
    .o_alu_a(a1), .o_alu_b(b1), .o_alu_opcode(op1), .o_alu_sel(s1),
    .i_alu_result(r1), .i_alu_carry(c1), .i_alu_overflow(o1), .i_alu_remainder(rm1),
    .o_busy(bz1), .o_op_count(opc1), .o_dz_count(dzc1)
  );

  alu_op_issuer #(.SETTLE_CYCLES(1), .CNT_W(2)) u2 (
    .i_clk(clk), .i_rst(rst), .bus(if2),
    .o_alu_a(a2), .o_alu_b(b2), .o_alu_opcode(op2), .o_alu_sel(s2),
    .i_alu_result(r2), .i_alu_carry(c2), .i_alu_overflow(o2), .i_alu_remainder(rm2),
    .o_busy(bz2), .o_op_count(opc2), .o_dz_count(dzc2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction on u0 with res_ready held high.
  task automatic run0(input string nm, input logic [3:0] a, input logic [3:0] b,
                      input logic [1:0] op, input logic [3:0] tag,
                      input logic [7:0] ed, input logic [3:0] er, input logic ec,
                      input logic eo, input logic edz,
                      input logic [7:0] eopc, input logic [7:0] edzc);
    @(negedge clk);
    chk({nm, ".cmd_ready_idle"}, 32'(if0.cmd_ready), 32'd1);
    if0.cmd_valid = 1'b1;
    if0.cmd_a     = a;
    if0.cmd_b     = b;
    if0.cmd_op    = op;
    if0.cmd_tag   = tag;
    @(negedge clk);
    if0.cmd_valid = 1'b0;
    chk({nm, ".busy"},      32'(bz0), 32'd1);
    chk({nm, ".cmd_ready"}, 32'(if0.cmd_ready), 32'd0);
    chk({nm, ".early_rv"},  32'(if0.res_valid), 32'd0);
    chk({nm, ".alu_a"},     32'(a0), 32'(a));
    chk({nm, ".alu_b"},     32'(b0), 32'(b));
    chk({nm, ".alu_op"},    32'(op0), 32'(op));
    @(negedge clk);
    chk({nm, ".res_valid"}, 32'(if0.res_valid), 32'd1);
    chk({nm, ".res_data"},  32'(if0.res_data), 32'(ed));
    chk({nm, ".res_rem"},   32'(if0.res_rem), 32'(er));
    chk({nm, ".res_carry"}, 32'(if0.res_carry), 32'(ec));
    chk({nm, ".res_ovf"},   32'(if0.res_ovf), 32'(eo));
    chk({nm, ".res_dz"},    32'(if0.res_dz), 32'(edz));
    chk({nm, ".res_tag"},   32'(if0.res_tag), 32'(tag));
    @(negedge clk);
    chk({nm, ".rv_drop"},   32'(if0.res_valid), 32'd0);
    chk({nm, ".ready_back"},32'(if0.cmd_ready), 32'd1);
    chk({nm, ".data_held"}, 32'(if0.res_data), 32'(ed));
    chk({nm, ".op_count"},  32'(opc0), 32'(eopc));
    chk({nm, ".dz_count"},  32'(dzc0), 32'(edzc));
  endtask

  initial begin
    rst = 1'b1;
    if0.cmd_valid = 1'b0; if0.cmd_a = 4'd0; if0.cmd_b = 4'd0; if0.cmd_op = 2'd0;
    if0.cmd_tag = 4'd0; if0.res_ready = 1'b1;
    if1.cmd_valid = 1'b0; if1.cmd_a = 4'd0; if1.cmd_b = 4'd0; if1.cmd_op = 2'd0;
    if1.cmd_tag = 4'd0; if1.res_ready = 1'b1;
    if2.cmd_valid = 1'b0; if2.cmd_a = 4'd0; if2.cmd_b = 4'd0; if2.cmd_op = 2'd0;
    if2.cmd_tag = 4'd0; if2.res_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.res_valid", 32'(if0.res_valid), 32'd0);
    chk("rst.res_data",  32'(if0.res_data), 32'd0);
    chk("rst.res_tag",   32'(if0.res_tag), 32'd0);
    chk("rst.alu_a",     32'(a0), 32'd0);
    chk("rst.alu_op",    32'(op0), 32'd0);
    chk("rst.op_count",  32'(opc0), 32'd0);
    chk("rst.busy",      32'(bz0), 32'd0);
    chk("rst.alu_sel",   32'(s0), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.cmd_ready", 32'(if0.cmd_ready), 32'd1);

    // u0: add, mul, div, divide by zero
    run0("add", 4'h7, 4'h3, 2'b00, 4'h5, 8'h0A, 4'h0, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
    run0("mul", 4'hF, 4'hF, 2'b10, 4'h1, 8'hE1, 4'h0, 1'b1, 1'b1, 1'b0, 8'd2, 8'd0);
    run0("div", 4'hD, 4'h4, 2'b11, 4'h2, 8'h03, 4'h1, 1'b0, 1'b0, 1'b0, 8'd3, 8'd0);
    run0("dz",  4'h9, 4'h0, 2'b11, 4'h3, 8'hFF, 4'hF, 1'b1, 1'b1, 1'b1, 8'd4, 8'd1);

    // u0: backpressure, 1+1 tag 9, with a competing command in the hold window
    if0.res_ready = 1'b0;
    @(negedge clk);
    if0.cmd_valid = 1'b1; if0.cmd_a = 4'h1; if0.cmd_b = 4'h1; if0.cmd_op = 2'b00;
    if0.cmd_tag = 4'h9;
    @(negedge clk);
    if0.cmd_valid = 1'b0;
    @(negedge clk);
    chk("bp.res_valid", 32'(if0.res_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.hold_valid", 32'(if0.res_valid), 32'd1);
      chk("bp.hold_data",  32'(if0.res_data), 32'h02);
      chk("bp.hold_tag",   32'(if0.res_tag), 32'h9);
      chk("bp.cmd_ready",  32'(if0.cmd_ready), 32'd0);
      chk("bp.alu_a_kept", 32'(a0), 32'h1);
      if (i == 1) begin
        if0.cmd_valid = 1'b1; if0.cmd_a = 4'h4; if0.cmd_b = 4'h6; if0.cmd_tag = 4'h3;
      end else begin
        if0.cmd_valid = 1'b0;
      end
    end
    chk("bp.op_count_hold", 32'(opc0), 32'd4);
    if0.res_ready = 1'b1;
    @(negedge clk);
    chk("bp.rv_drop",   32'(if0.res_valid), 32'd0);
    chk("bp.ready",     32'(if0.cmd_ready), 32'd1);
    chk("bp.op_count",  32'(opc0), 32'd5);
    chk("bp.dz_count",  32'(dzc0), 32'd1);
    chk("bp.tag_held",  32'(if0.res_tag), 32'h9);

    // u1: SETTLE_CYCLES=3, sub 2-5 tag 6
    @(negedge clk);
    if1.cmd_valid = 1'b1; if1.cmd_a = 4'h2; if1.cmd_b = 4'h5; if1.cmd_op = 2'b01;
    if1.cmd_tag = 4'h6;
    @(negedge clk);
    if1.cmd_valid = 1'b0;
    chk("s3.rv_n0", 32'(if1.res_valid), 32'd0);
    @(negedge clk);
    chk("s3.rv_n1", 32'(if1.res_valid), 32'd0);
    @(negedge clk);
    chk("s3.rv_n2", 32'(if1.res_valid), 32'd0);
    chk("s3.busy",  32'(bz1), 32'd1);
    @(negedge clk);
    chk("s3.rv_n3",     32'(if1.res_valid), 32'd1);
    chk("s3.res_data",  32'(if1.res_data), 32'hFD);
    chk("s3.res_carry", 32'(if1.res_carry), 32'd1);
    chk("s3.res_ovf",   32'(if1.res_ovf), 32'd0);
    chk("s3.res_tag",   32'(if1.res_tag), 32'h6);
    @(negedge clk);
    chk("s3.rv_drop",   32'(if1.res_valid), 32'd0);
    chk("s3.op_count",  32'(opc1), 32'd1);

    // u1: reset while in WAIT
    if1.cmd_valid = 1'b1; if1.cmd_a = 4'h3; if1.cmd_b = 4'h3; if1.cmd_op = 2'b00;
    if1.cmd_tag = 4'h2;
    @(negedge clk);
    if1.cmd_valid = 1'b0;
    chk("mr.busy_before", 32'(bz1), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mr.busy_in_rst", 32'(bz1), 32'd0);
    chk("mr.rv_in_rst",   32'(if1.res_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mr.cmd_ready", 32'(if1.cmd_ready), 32'd1);
    chk("mr.op_count",  32'(opc1), 32'd0);
    chk("mr.res_data",  32'(if1.res_data), 32'd0);
    chk("mr.u0_opcnt",  32'(opc0), 32'd0);
    chk("mr.u0_dzcnt",  32'(dzc0), 32'd0);
    repeat (4) @(negedge clk);
    chk("mr.rv_stays0", 32'(if1.res_valid), 32'd0);

    // u2: CNT_W=2, five ops saturate op_count at 3
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if2.cmd_valid = 1'b1; if2.cmd_a = 4'(i); if2.cmd_b = 4'h1; if2.cmd_op = 2'b00;
      if2.cmd_tag = 4'(i);
      @(negedge clk);
      if2.cmd_valid = 1'b0;
      @(negedge clk);
      chk("sat.res_data", 32'(if2.res_data), 32'(i + 1));
      @(negedge clk);
      chk("sat.op_count", 32'(opc2), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    chk("sat.dz_count", 32'(dzc2), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
